// File: rtl/nasti_stream_reader.sv
// Read-side DMA mover: fetches a memory region over NASTI AR/R
// and replays it as a stream, one INCR burst in flight at a time.
module nasti_stream_reader #(
  parameter  int ADDR_WIDTH       = 46,
  parameter  int DATA_WIDTH       = 64,
  parameter  int MAX_BURST_LENGTH = 8,
  localparam int ADDR_SHIFT       = $clog2(DATA_WIDTH/8),
  localparam int WA               = ADDR_WIDTH - ADDR_SHIFT,
  localparam int CMD_WIDTH        = WA + 24,
  localparam int SW               = DATA_WIDTH/8
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  cmd_t_valid,
  output logic                  cmd_t_ready,
  input  logic [CMD_WIDTH-1:0]  cmd_t_data,
  output logic                  ar_valid,
  input  logic                  ar_ready,
  output logic [ADDR_WIDTH-1:0] ar_addr,
  output logic [7:0]            ar_len,
  output logic [2:0]            ar_size,
  output logic [1:0]            ar_burst,
  input  logic                  r_valid,
  output logic                  r_ready,
  input  logic [DATA_WIDTH-1:0] r_data,
  input  logic [1:0]            r_resp,
  input  logic                  r_last,
  output logic                  dst_t_valid,
  input  logic                  dst_t_ready,
  output logic [DATA_WIDTH-1:0] dst_t_data,
  output logic [SW-1:0]         dst_t_strb,
  output logic [SW-1:0]         dst_t_keep,
  output logic                  dst_t_last,
  output logic                  busy,
  output logic                  err
);

  localparam int PW = 12 - ADDR_SHIFT;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    DRAIN
  } state_t;

  state_t state, nstate;

  logic [WA-1:0] waddr;
  logic [16:0]   rem;
  logic [8:0]    cnt;
  logic [16:0]   bnd;
  logic [16:0]   blen;
  logic [WA-1:0] cmd_addr;
  logic [15:0]   cmd_len;
  logic          cmd_fire;
  logic          ar_fire;
  logic          r_fire;
  logic          drain_done;
  logic          unused_rsvd;

  assign cmd_addr    = cmd_t_data[CMD_WIDTH-1:24];
  assign cmd_len     = cmd_t_data[23:8];
  assign unused_rsvd = ^cmd_t_data[7:0];

  assign cmd_t_ready = (state == IDLE) && !areset;
  assign ar_valid    = (state == ADDR);
  assign r_ready     = (state == DATA) &&
                       (!dst_t_valid || dst_t_ready);

  assign cmd_fire = cmd_t_valid && cmd_t_ready;
  assign ar_fire  = ar_valid && ar_ready;
  assign r_fire   = r_valid && r_ready;

  assign drain_done = !dst_t_valid ||
                      (dst_t_ready && dst_t_last);

  assign ar_addr  = {waddr, {ADDR_SHIFT{1'b0}}};
  assign ar_len   = 8'(blen - 17'd1);
  assign ar_size  = 3'(ADDR_SHIFT);
  assign ar_burst = 2'b01;

  assign dst_t_strb = '1;
  assign dst_t_keep = '1;
  assign busy       = (state != IDLE);

  // burst length: clipped by max burst, remaining words and 4 KiB page
  always_comb begin
    bnd  = 17'(1 << PW) - 17'(waddr[PW-1:0]);
    blen = rem;
    if (bnd < blen)
      blen = bnd;
    if (17'(MAX_BURST_LENGTH) < blen)
      blen = 17'(MAX_BURST_LENGTH);
  end

  // state register
  always_ff @(posedge aclk) begin
    if (areset)
      state <= IDLE;
    else
      state <= nstate;
  end

  // next-state decode
  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:
        if (cmd_fire && cmd_len != 16'd0)
          nstate = ADDR;
      ADDR:
        if (ar_fire)
          nstate = DATA;
      DATA:
        if (r_fire && cnt == 9'd1)
          nstate = (rem == 17'd1) ? DRAIN : ADDR;
      DRAIN:
        if (drain_done)
          nstate = IDLE;
      default:
        nstate = IDLE;
    endcase
  end

  // address/count bookkeeping
  always_ff @(posedge aclk) begin
    if (cmd_fire) begin
      waddr <= cmd_addr;
      rem   <= {1'b0, cmd_len};
    end
    if (ar_fire)
      cnt <= 9'(blen);
    if (r_fire) begin
      cnt   <= cnt - 9'd1;
      rem   <= rem - 17'd1;
      waddr <= waddr + WA'(1);
    end
  end

  // one-entry output register plus sticky error
  always_ff @(posedge aclk) begin
    if (areset) begin
      dst_t_valid <= 1'b0;
      dst_t_last  <= 1'b0;
      err         <= 1'b0;
    end else begin
      if (r_fire) begin
        dst_t_data  <= r_data;
        dst_t_valid <= 1'b1;
        dst_t_last  <= (rem == 17'd1);
        if (r_resp != 2'b00 ||
            r_last != (cnt == 9'd1))
          err <= 1'b1;
      end else if (dst_t_ready) begin
        dst_t_valid <= 1'b0;
        dst_t_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nasti_stream_reader.sv
// Directed bench for nasti_stream_reader with a
// behavioural NASTI read slave and a stream monitor.
module tb_nasti_stream_reader;

  localparam int AW = 46;
  localparam int DW = 64;
  localparam int CW = AW - 3 + 24;

  logic          aclk = 1'b0;
  logic          areset;
  logic          cmd_t_valid;
  logic          cmd_t_ready;
  logic [CW-1:0] cmd_t_data;
  logic          ar_valid;
  logic          ar_ready;
  logic [AW-1:0] ar_addr;
  logic [7:0]    ar_len;
  logic [2:0]    ar_size;
  logic [1:0]    ar_burst;
  logic          r_valid;
  logic          r_ready;
  logic [DW-1:0] r_data;
  logic [1:0]    r_resp;
  logic          r_last;
  logic          dst_t_valid;
  logic          dst_t_ready;
  logic [DW-1:0] dst_t_data;
  logic [7:0]    dst_t_strb;
  logic [7:0]    dst_t_keep;
  logic          dst_t_last;
  logic          busy;
  logic          err;

  always #5 aclk = ~aclk;

  nasti_stream_reader dut (
    .aclk        (aclk),
    .areset      (areset),
    .cmd_t_valid (cmd_t_valid),
    .cmd_t_ready (cmd_t_ready),
    .cmd_t_data  (cmd_t_data),
    .ar_valid    (ar_valid),
    .ar_ready    (ar_ready),
    .ar_addr     (ar_addr),
    .ar_len      (ar_len),
    .ar_size     (ar_size),
    .ar_burst    (ar_burst),
    .r_valid     (r_valid),
    .r_ready     (r_ready),
    .r_data      (r_data),
    .r_resp      (r_resp),
    .r_last      (r_last),
    .dst_t_valid (dst_t_valid),
    .dst_t_ready (dst_t_ready),
    .dst_t_data  (dst_t_data),
    .dst_t_strb  (dst_t_strb),
    .dst_t_keep  (dst_t_keep),
    .dst_t_last  (dst_t_last),
    .busy        (busy),
    .err         (err)
  );

  // read slave: word at byte address a holds C0DE.. | a
  logic [AW-1:0] s_addr;
  logic [8:0]    s_left;
  logic          s_act;
  logic [AW-1:0] inj_addr;

  assign ar_ready = 1'b1;
  assign r_valid  = s_act;
  assign r_data   = 64'hC0DE_0000_0000_0000 | 64'(s_addr);
  assign r_last   = (s_left == 9'd1);
  assign r_resp   = (s_act && s_addr == inj_addr) ? 2'b10 : 2'b00;

  always @(posedge aclk) begin
    if (areset)
      s_act <= 1'b0;
    else if (s_act) begin
      if (r_ready) begin
        s_addr <= s_addr + 46'd8;
        s_left <= s_left - 9'd1;
        if (s_left == 9'd1)
          s_act <= 1'b0;
      end
    end else if (ar_valid) begin
      s_act  <= 1'b1;
      s_addr <= ar_addr;
      s_left <= 9'(ar_len) + 9'd1;
    end
  end

  // monitor: logs AR and dst handshakes, watches stall rules
  logic [DW-1:0] wq[$];
  logic          lq[$];
  logic [AW-1:0] aq[$];
  logic [7:0]    lenq[$];
  int            stall_viol = 0;
  int            rr_viol = 0;
  logic          stalled = 1'b0;
  logic [DW-1:0] held;
  logic          busy_after_last;

  always @(posedge aclk) begin
    if (areset)
      stalled = 1'b0;
    else begin
      if (ar_valid && ar_ready) begin
        aq.push_back(ar_addr);
        lenq.push_back(ar_len);
      end
      if (dst_t_valid && dst_t_ready) begin
        wq.push_back(dst_t_data);
        lq.push_back(dst_t_last);
      end
      if (stalled && (!dst_t_valid || dst_t_data !== held))
        stall_viol++;
      stalled = dst_t_valid && !dst_t_ready;
      held    = dst_t_data;
      if (r_ready && dst_t_valid && !dst_t_ready)
        rr_viol++;
      if (dst_t_valid && dst_t_ready && dst_t_last) begin
        #1 busy_after_last = busy;
      end
    end
  end

  int vecs = 0;
  int miss = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pat(input logic [AW-1:0] a);
    return 64'hC0DE_0000_0000_0000 | 64'(a);
  endfunction

  task automatic send(input logic [AW-1:0] a, input int len);
    @(negedge aclk);
    chk("cmd_ready", 64'(cmd_t_ready), 64'd1);
    cmd_t_valid = 1'b1;
    cmd_t_data  = {a[AW-1:3], 16'(len), 8'h00};
    @(negedge aclk);
    cmd_t_valid = 1'b0;
  endtask

  task automatic run(input bit rnd, input string tag);
    int n;
    n = 0;
    while ((busy || dst_t_valid) && n < 500) begin
      dst_t_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge aclk);
      n++;
    end
    dst_t_ready = 1'b1;
    chk({tag, "_done"}, 64'(n < 500), 64'd1);
  endtask

  task automatic words(input string tag, input int base,
                       input logic [AW-1:0] a, input int len);
    chk({tag, "_count"}, 64'(wq.size() - base), 64'(len));
    for (int i = 0; i < len && base + i < wq.size(); i++) begin
      chk($sformatf("%s_w%0d", tag, i), wq[base+i],
          pat(a + AW'(8 * i)));
      chk($sformatf("%s_l%0d", tag, i), 64'(lq[base+i]),
          64'(i == len - 1));
    end
  endtask

  task automatic ar_at(input string tag, input int base, input int idx,
                       input logic [AW-1:0] a, input logic [7:0] l);
    if (base + idx < aq.size()) begin
      chk({tag, "_addr"}, 64'(aq[base+idx]), 64'(a));
      chk({tag, "_len"}, 64'(lenq[base+idx]), 64'(l));
    end else
      chk({tag, "_present"}, 64'(aq.size()), 64'(base + idx + 1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wb, ab;
    areset      = 1'b1;
    cmd_t_valid = 1'b0;
    cmd_t_data  = '0;
    dst_t_ready = 1'b1;
    inj_addr    = '1;
    repeat (3) @(negedge aclk);
    chk("reset_outs",
        64'({cmd_t_ready, ar_valid, r_ready, dst_t_valid,
             dst_t_last, busy, err}), 64'd0);
    areset = 1'b0;
    @(negedge aclk);
    chk("ar_size", 64'(ar_size), 64'd3);
    chk("ar_burst", 64'(ar_burst), 64'd1);
    chk("strb_keep", 64'({dst_t_strb, dst_t_keep}), 64'hFFFF);

    // single aligned burst
    wb = wq.size(); ab = aq.size();
    send(46'h1000, 8);
    run(1'b0, "t1");
    chk("t1_nar", 64'(aq.size() - ab), 64'd1);
    ar_at("t1_ar0", ab, 0, 46'h1000, 8'd7);
    words("t1", wb, 46'h1000, 8);
    chk("t1_busy_after_last", 64'(busy_after_last), 64'd0);

    // split into max-length bursts
    wb = wq.size(); ab = aq.size();
    send(46'h0, 20);
    run(1'b0, "t2");
    chk("t2_nar", 64'(aq.size() - ab), 64'd3);
    ar_at("t2_ar0", ab, 0, 46'h000, 8'd7);
    ar_at("t2_ar1", ab, 1, 46'h040, 8'd7);
    ar_at("t2_ar2", ab, 2, 46'h080, 8'd3);
    words("t2", wb, 46'h0, 20);

    // 4 KiB boundary split
    wb = wq.size(); ab = aq.size();
    send(46'hFE0, 8);
    run(1'b0, "t3");
    chk("t3_nar", 64'(aq.size() - ab), 64'd2);
    ar_at("t3_ar0", ab, 0, 46'hFE0, 8'd3);
    ar_at("t3_ar1", ab, 1, 46'h1000, 8'd3);
    words("t3", wb, 46'hFE0, 8);

    // random backpressure on dst
    wb = wq.size();
    send(46'h2000, 16);
    run(1'b1, "t4");
    words("t4", wb, 46'h2000, 16);
    chk("t4_stall_stable", 64'(stall_viol), 64'd0);
    chk("t4_r_ready_rule", 64'(rr_viol), 64'd0);

    // error response on beat 3
    chk("t5_err_before", 64'(err), 64'd0);
    inj_addr = 46'h3010;
    wb = wq.size();
    send(46'h3000, 4);
    run(1'b0, "t5");
    inj_addr = '1;
    words("t5", wb, 46'h3000, 4);
    chk("t5_err_set", 64'(err), 64'd1);
    wb = wq.size();
    send(46'h3100, 2);
    run(1'b0, "t5b");
    words("t5b", wb, 46'h3100, 2);
    chk("t5_err_sticky", 64'(err), 64'd1);

    // zero-length command
    wb = wq.size(); ab = aq.size();
    send(46'h5000, 0);
    repeat (4) @(negedge aclk);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_no_ar", 64'(aq.size() - ab), 64'd0);
    chk("t6_no_words", 64'(wq.size() - wb), 64'd0);
    chk("t6_ready", 64'(cmd_t_ready), 64'd1);

    // reset in the middle of a burst
    dst_t_ready = 1'b0;
    send(46'h6000, 16);
    repeat (4) @(negedge aclk);
    chk("t7_busy_mid", 64'(busy), 64'd1);
    chk("t7_full_mid", 64'(dst_t_valid), 64'd1);
    areset = 1'b1;
    @(negedge aclk);
    chk("t7_reset_outs",
        64'({cmd_t_ready, ar_valid, r_ready, dst_t_valid,
             dst_t_last, busy, err}), 64'd0);
    areset      = 1'b0;
    dst_t_ready = 1'b1;
    @(negedge aclk);
    chk("t7_idle", 64'({cmd_t_ready, busy}), 64'b10);
    wb = wq.size(); ab = aq.size();
    send(46'h7000, 3);
    run(1'b0, "t7");
    chk("t7_nar", 64'(aq.size() - ab), 64'd1);
    ar_at("t7_ar0", ab, 0, 46'h7000, 8'd2);
    words("t7", wb, 46'h7000, 3);
    chk("t7_err_clear", 64'(err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
